// File: rtl/segre_lsu.sv
// Load/store unit: single-outstanding req/ack data-memory port with alignment
// checking, byte-lane steering for stores and lane extraction/extension for loads.
module segre_lsu #(
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic                 memop_rd_i,
    input  logic                 memop_wr_i,
    input  logic [1:0]           memop_type_i,
    input  logic                 memop_sign_ext_i,
    input  logic [WORD_SIZE-1:0] addr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic [REG_SIZE-1:0]  waddr_i,
    output logic                 busy_o,
    output logic                 err_o,
    output logic                 done_o,
    output logic                 rf_we_o,
    output logic [REG_SIZE-1:0]  rf_waddr_o,
    output logic [WORD_SIZE-1:0] rf_wdata_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [WORD_SIZE-1:0] mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [WORD_SIZE-1:0] mem_wdata_o,
    input  logic                 mem_ack_i,
    input  logic [WORD_SIZE-1:0] mem_rdata_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] TYPE_BYTE = 2'd0;
    localparam logic [1:0] TYPE_HALF = 2'd1;
    localparam logic [1:0] TYPE_WORD = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 we_q, we_d;
    logic [1:0]           type_q, type_d;
    logic                 sext_q, sext_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [3:0]           be_q, be_d;
    logic [REG_SIZE-1:0]  waddr_q, waddr_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 misaligned_s;

    function automatic logic [3:0] calc_be(input logic [1:0] ty, input logic [1:0] off);
        case (ty)
            TYPE_BYTE: calc_be = 4'b0001 << off;
            TYPE_HALF: calc_be = 4'b0011 << off;
            TYPE_WORD: calc_be = 4'b1111;
            default:   calc_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [WORD_SIZE-1:0] replicate(input logic [1:0] ty,
                                                       input logic [WORD_SIZE-1:0] d);
        case (ty)
            TYPE_BYTE: replicate = {4{d[7:0]}};
            TYPE_HALF: replicate = {2{d[15:0]}};
            default:   replicate = d;
        endcase
    endfunction

    function automatic logic [WORD_SIZE-1:0] extract(input logic [1:0] ty, input logic sx,
                                                     input logic [1:0] off,
                                                     input logic [WORD_SIZE-1:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (ty)
            TYPE_BYTE: extract = {{24{sx & b[7]}}, b};
            TYPE_HALF: extract = {{16{sx & h[15]}}, h};
            default:   extract = d;
        endcase
    endfunction

    // Alignment check of the presented memop
    always_comb begin
        case (memop_type_i)
            TYPE_BYTE: misaligned_s = 1'b0;
            TYPE_HALF: misaligned_s = addr_i[0];
            TYPE_WORD: misaligned_s = |addr_i[1:0];
            default:   misaligned_s = 1'b1;
        endcase
    end

    // Next-state and request-field capture
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        type_d  = type_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        waddr_d = waddr_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i && (memop_rd_i ^ memop_wr_i)) begin
                    if (misaligned_s) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        we_d    = memop_wr_i;
                        type_d  = memop_type_i;
                        sext_d  = memop_sign_ext_i;
                        addr_d  = addr_i;
                        wdata_d = replicate(memop_type_i, wdata_i);
                        be_d    = calc_be(memop_type_i, addr_i[1:0]);
                        waddr_d = waddr_i;
                    end
                end else if (valid_i && memop_rd_i && memop_wr_i) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack_i) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        rdata_d = extract(type_q, sext_q, addr_q[1:0], mem_rdata_i);
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched request registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            type_q  <= 2'd0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0000;
            waddr_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            type_q  <= type_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            waddr_q <= waddr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err_q;
    assign done_o      = (state_q == ST_RESP);
    assign rf_we_o     = (state_q == ST_RESP) & ~we_q;
    assign rf_waddr_o  = waddr_q;
    assign rf_wdata_o  = rdata_q;
    assign mem_req_o   = (state_q == ST_REQ);
    assign mem_we_o    = (state_q == ST_REQ) & we_q;
    assign mem_addr_o  = {addr_q[WORD_SIZE-1:2], 2'b00};
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: doc/segre_lsu.md
# segre_lsu

Load/store unit that executes the memory operations selected by the decode stage. It takes the decoded memop controls (read/write, data type, sign extension), the ALU-computed effective address and the store data. It drives a single-outstanding request/acknowledge word interface to data memory. It returns sign- or zero-extended load data with a register-file write strobe, and holds a busy flag that stalls the pipeline while an access is in flight.

## Interface
Parameters:
- WORD_SIZE, 32, data and address width
- REG_SIZE, 5, register-file address width

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset; asynchronous, active-high
- valid_i  in  1  memop presented this cycle
- memop_rd_i  in  1  load
- memop_wr_i  in  1  store
- memop_type_i  in  memop_data_type_e  BYTE / HALF / WORD
- memop_sign_ext_i  in  1  sign-extend load result (1) or zero-extend (0)
- addr_i  in  WORD_SIZE  effective byte address
- wdata_i  in  WORD_SIZE  store data (rs2)
- waddr_i  in  REG_SIZE  load destination register
- busy_o  out  1  unit not idle; new memops are not accepted
- err_o  out  1  one-cycle pulse: misaligned or malformed memop rejected
- done_o  out  1  one-cycle pulse: access completed
- rf_we_o  out  1  one-cycle load write-back strobe
- rf_waddr_o  out  REG_SIZE  write-back register
- rf_wdata_o  out  WORD_SIZE  extended load data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  request is a write
- mem_addr_o  out  WORD_SIZE  word-aligned address ({addr[31:2],2'b00})
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  WORD_SIZE  lane-replicated store data
- mem_ack_i  in  1  memory completed the request; read data valid this cycle
- mem_rdata_i  in  WORD_SIZE  read word

## Operation
- FSM states: IDLE, REQ, RESP. Reset state is IDLE.
- IDLE, with valid_i and exactly one of rd/wr set:
  - Aligned: latch all request fields, then go to REQ.
  - Misaligned (HALF with addr[0]=1, or WORD with addr[1:0]≠0): pulse err_o next cycle, stay IDLE, no memory access.
- IDLE, with valid_i and rd=wr=1: rejected the same way (err_o pulse, no access).
- IDLE, with valid_i and rd=wr=0: ignored.
- valid_i is ignored outside IDLE.
- Byte enables: BYTE = 4'b0001<<addr[1:0]; HALF = 4'b0011<<addr[1:0]; WORD = 4'b1111.
- Store data replication: BYTE = {4{wdata[7:0]}}; HALF = {2{wdata[15:0]}}; WORD = wdata.
- REQ: mem_req_o=1 with stable mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o until mem_ack_i is sampled high. On ack:
  - Load: capture mem_rdata_i.
  - Go to RESP.
- RESP: done_o=1. For loads also:
  - rf_we_o=1 and rf_waddr_o=latched waddr.
  - rf_wdata_o = selected lane (byte addr[1:0], half addr[1]) extended to 32 bits per the sign_ext flag.
  - Then go to IDLE.
- mem_ack_i outside REQ is ignored.

## Timing
- All outputs are registered or decoded from registered state.
- Reset values: busy_o, err_o, done_o, rf_we_o, mem_req_o and mem_we_o are 0; mem_be_o is 0; all data and address outputs are 0.
- Accept at cycle N. mem_req_o and busy_o are high from N+1.
- Ack sampled at cycle M≥N+1. mem_req_o drops at M+1.
- done_o (and rf_we_o for loads) is high during cycle M+1 only. busy_o is high through M+1 and low at M+2.
- Minimum accept-to-accept spacing is 3 cycles (zero-wait memory acks at N+1).
- err_o is asserted at N+1 for one cycle; busy_o stays 0.
- rf_wdata_o holds its value between loads; it is only meaningful with rf_we_o.
- Reset asserted mid-operation immediately (asynchronously) clears mem_req_o, busy_o and all pulses, and returns the FSM to IDLE. A later mem_ack_i for the aborted request is ignored.

## Test plan
- LW at addr 0x100, memory acks two cycles after req with rdata 0xDEADBEEF -> mem_addr_o=0x100, be=1111, we=0; rf_we_o one cycle with rf_wdata_o=0xDEADBEEF; busy_o high for exactly 4 cycles.
- LB at 0x203 (sign_ext=1) with rdata 0x80FF_0000 -> be=1000, rf_wdata_o=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x202 -> 0x000080FF.
- SH at 0x302 with wdata 0x1234ABCD, zero-wait ack -> mem_addr_o=0x300, be=1100, mem_wdata_o=0xABCDABCD, we=1; done_o pulse with no rf_we_o.
- SW at 0x401 and LH at 0x501 -> err_o pulse each, mem_req_o never asserted, busy_o stays 0. Memop with rd=wr=1 -> err_o.
- valid_i held high with a second LW while busy; stall ack for 10 cycles -> second LW is not accepted until IDLE; mem_req_o stays high and stable for all 10 cycles.
- Assert rst_i in REQ, then deliver mem_ack_i after release -> mem_req_o low immediately, no done_o/rf_we_o pulse, next LW completes normally.
